// File: rtl/clock_monitor.sv
// clock_monitor: measures an asynchronous square wave against clk.
// Reports rising edges per gate window (freq_count), the length of the last
// complete high/low phase in cycles (half_period), and flags a stalled input.
module clock_monitor #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned TIMEOUT     = 200000000,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] freq_count,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sdly_q, sdly_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             armed_q, armed_d;
  logic             valid_q, valid_d;
  logic             stalled_q, stalled_d;
  logic             rise;
  logic             edg;

  // Synchronized edge detection: s is sync2_q, s_d is sdly_q.
  assign rise = sync2_q & ~sdly_q;
  assign edg  = sync2_q ^ sdly_q;

  // Next-state logic for synchronizer, gate window, edge and phase counters.
  always_comb begin
    sync1_d   = sig_in;
    sync2_d   = sync1_q;
    sdly_d    = sync2_q;
    gcnt_d    = gcnt_q;
    ecnt_d    = ecnt_q;
    pcnt_d    = pcnt_q;
    freq_d    = freq_q;
    half_d    = half_q;
    armed_d   = armed_q;
    valid_d   = 1'b0;
    stalled_d = 1'b0;

    if (en) begin
      // A rise in the terminal cycle belongs to the closing window.
      if (gcnt_q == GATE_LAST) begin
        gcnt_d  = '0;
        freq_d  = (rise && (ecnt_q != CNT_MAX)) ? ecnt_q + ONE : ecnt_q;
        ecnt_d  = '0;
        valid_d = 1'b1;
      end else begin
        gcnt_d = gcnt_q + ONE;
        if (rise && (ecnt_q != CNT_MAX))
          ecnt_d = ecnt_q + ONE;
      end

      // Phases that hit TIMEOUT or started before arming are discarded.
      if (edg) begin
        pcnt_d  = ONE;
        if (armed_q && (pcnt_q < TO_VAL))
          half_d = pcnt_q;
        armed_d = 1'b1;
      end else if (pcnt_q < TO_VAL) begin
        pcnt_d = pcnt_q + ONE;
      end

      // Cleared directly by an edge so it drops the cycle after that edge.
      stalled_d = (pcnt_q == TO_VAL) && !edg;
    end else begin
      gcnt_d  = '0;
      ecnt_d  = '0;
      pcnt_d  = '0;
      armed_d = 1'b0;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sdly_q    <= 1'b0;
      gcnt_q    <= '0;
      ecnt_q    <= '0;
      pcnt_q    <= '0;
      freq_q    <= '0;
      half_q    <= '0;
      armed_q   <= 1'b0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sdly_q    <= sdly_d;
      gcnt_q    <= gcnt_d;
      ecnt_q    <= ecnt_d;
      pcnt_q    <= pcnt_d;
      freq_q    <= freq_d;
      half_q    <= half_d;
      armed_q   <= armed_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
    end
  end

  assign freq_count  = freq_q;
  assign half_period = half_q;
  assign meas_valid  = valid_q;
  assign stalled     = stalled_q;

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: randomized stimulus checked every cycle against a
// timestamp-based reference model, plus directed checks of key scenarios.
module tb_clock_monitor;
  localparam int GATE = 1000;
  localparam int TMO  = 500;
  localparam int W    = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig_in = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] freq_count;
  logic [W-1:0] half_period;
  logic         meas_valid;
  logic         stalled;

  always #5 clk = ~clk;

  clock_monitor #(.GATE_CYCLES(GATE), .TIMEOUT(TMO), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
    .freq_count(freq_count), .half_period(half_period),
    .meas_valid(meas_valid), .stalled(stalled)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: sampled input delay line, then window/phase rules from
  // cycle timestamps measured since the start of the enabled span.
  bit          ma, mb, mc;
  int          tcur;
  int          last_edge;
  int          rise_q[$];
  logic [31:0] e_freq, e_half;
  bit          e_valid, e_stalled;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma = 0; mb = 0; mc = 0;
      tcur = 0; last_edge = -1; rise_q.delete();
      e_freq = 0; e_half = 0; e_valid = 0; e_stalled = 0;
    end else begin
      bit r, e;
      int t, ref_t, cnt;
      r = mb & ~mc;
      e = mb ^ mc;
      if (en) begin
        t = tcur;
        if (r) rise_q.push_back(t);
        e_valid = ((t % GATE) == GATE - 1);
        if (e_valid) begin
          cnt = 0;
          foreach (rise_q[i]) if (rise_q[i] / GATE == t / GATE) cnt++;
          e_freq = cnt;
          rise_q.delete();
        end
        ref_t = (last_edge >= 0) ? last_edge : 0;
        e_stalled = !e && (t - ref_t >= TMO);
        if (e) begin
          if (last_edge >= 0 && t - last_edge < TMO) e_half = t - last_edge;
          last_edge = t;
        end
        tcur = t + 1;
      end else begin
        tcur = 0; last_edge = -1; rise_q.delete();
        e_valid = 0; e_stalled = 0;
      end
      mc = mb; mb = ma; ma = sig_in;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check_val("meas_valid", {31'd0, meas_valid}, {31'd0, e_valid});
      check_val("stalled", {31'd0, stalled}, {31'd0, e_stalled});
      check_val("freq_count", freq_count, e_freq);
      check_val("half_period", half_period, e_half);
    end
  end

  task automatic toggle_run(input int period, input int n);
    repeat (n) begin
      sig_in = ~sig_in;
      repeat (period) @(negedge clk);
    end
  endtask

  task automatic wait_valid(input string tag);
    int  k;
    bit  seen;
    k = 0; seen = 0;
    while (!seen && k < 3 * GATE) begin
      @(negedge clk);
      k++;
      if (meas_valid) seen = 1;
    end
    if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int  n, nv;
    bit  seen, ok;
    rst = 1; en = 1; sig_in = 0;
    chk_on = 1;
    repeat (3) @(negedge clk);
    check_val("reset_freq", freq_count, 0);
    check_val("reset_half", half_period, 0);
    #1 rst = 0;

    // First window after release with an idle input.
    n = 0; seen = 0;
    while (!seen && n < 2 * GATE) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (meas_valid) seen = 1;
    end
    check_val("first_valid_cycles", n, GATE);
    check_val("first_freq", freq_count, 0);

    // Nominal rate.
    toggle_run(50, 60);
    check_val("nominal_half", half_period, 50);
    check_val("nominal_freq", freq_count, 10);

    // Odd rate.
    toggle_run(7, 600);
    check_val("odd_half", half_period, 7);
    ok = (freq_count == 71) || (freq_count == 72);
    check_val("odd_freq_range", {31'd0, ok}, 32'd1);

    // Rise landing exactly on the terminal cycle of a window.
    sig_in = 0;
    wait_valid("term_a");
    while (((tcur + 2) % GATE) != GATE - 1) @(negedge clk);
    sig_in = 1;
    wait_valid("term_b");
    check_val("term_edge_closing", freq_count, 1);
    wait_valid("term_c");
    check_val("term_next_window", freq_count, 0);
    sig_in = 0;
    repeat (20) @(negedge clk);

    // Stall and recovery.
    toggle_run(50, 6);
    repeat (800) @(negedge clk);
    check_val("stall_set", {31'd0, stalled}, 32'd1);
    check_val("stall_half_hold", half_period, 50);
    sig_in = ~sig_in;
    repeat (5) @(negedge clk);
    check_val("stall_clear", {31'd0, stalled}, 32'd0);
    check_val("stall_half_kept", half_period, 50);
    repeat (45) @(negedge clk);
    toggle_run(50, 4);
    check_val("stall_half_again", half_period, 50);

    // Enable gap mid-window.
    toggle_run(7, 50);
    en = 0;
    @(negedge clk);
    nv = 0;
    repeat (300) begin
      @(negedge clk);
      if (meas_valid) nv++;
    end
    check_val("gap_no_valid", nv, 0);
    check_val("gap_freq_hold", freq_count, e_freq);
    en = 1;
    toggle_run(7, 20);

    // Randomized segments: rates, long holds and enable gaps.
    for (int s = 0; s < 20; s++) begin
      int p, nt, sel;
      p   = $urandom_range(2, 80);
      nt  = $urandom_range(4, 40);
      sel = $urandom_range(0, 3);
      toggle_run(p, nt);
      if (sel == 0) begin
        en = 0;
        repeat ($urandom_range(1, 400)) @(negedge clk);
        en = 1;
      end else if (sel == 1) begin
        repeat ($urandom_range(400, 900)) @(negedge clk);
      end
    end

    // Asynchronous reset mid-window while the input toggles.
    toggle_run(5, 40);
    @(posedge clk);
    #3 rst = 1;
    #1;
    check_val("async_rst_freq", freq_count, 0);
    check_val("async_rst_half", half_period, 0);
    check_val("async_rst_valid", {31'd0, meas_valid}, 32'd0);
    check_val("async_rst_stalled", {31'd0, stalled}, 32'd0);
    @(negedge clk);
    rst = 0;
    toggle_run(9, 30);
    repeat (5) @(negedge clk);

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
